// File: rtl/ahb_sram_pkg.sv
// Shared encodings, FSM states and lane helpers for the AHB-to-SRAM bridge.
// Imported by the bridge, its interface and the lane decoder.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int DATA_W = LANES * LANE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } state_t;

    // Expands per-lane enables into a per-bit mask.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] lanes);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < LANES; i++) begin
            mask[i*LANE_W +: LANE_W] = {LANE_W{lanes[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_bridge_if.sv
// AHB slave bus plus SRAM port bundle. The slave modport is the bridge side;
// the master modport is the bus master together with the SRAM macro.
interface ahb_sram_bridge_if #(
    parameter int AW = 16
);
    import ahb_sram_pkg::*;

    logic              HSEL;
    logic              HREADY;
    logic [1:0]        HTRANS;
    logic [2:0]        HSIZE;
    logic              HWRITE;
    logic [31:0]       HADDR;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADYOUT;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;

    logic [AW-1:0]     SRAMADDR;
    logic [DATA_W-1:0] SRAMWDATA;
    logic [LANES-1:0]  SRAMWREN;
    logic              SRAMCS;
    logic [DATA_W-1:0] SRAMRDATA;

    modport slave (
        input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, SRAMRDATA,
        output HREADYOUT, HRESP, HRDATA, SRAMADDR, SRAMWDATA, SRAMWREN, SRAMCS
    );

    modport master (
        output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, SRAMRDATA,
        input  HREADYOUT, HRESP, HRDATA, SRAMADDR, SRAMWDATA, SRAMWREN, SRAMCS
    );

endinterface

// File: rtl/ahb_sram_lane_decode.sv
// Byte-lane and alignment decode for one AHB transfer.
// Lanes are forced to zero for illegal (oversized or misaligned) transfers.
module ahb_sram_lane_decode
    import ahb_sram_pkg::*;
(
    input  logic [2:0]       i_hsize,
    input  logic [1:0]       i_addr_lo,
    output logic [LANES-1:0] o_lanes,
    output logic             o_illegal
);

    assign o_illegal = (i_hsize > HSIZE_WORD)
                    || ((i_hsize == HSIZE_HALF) && i_addr_lo[0])
                    || ((i_hsize == HSIZE_WORD) && (i_addr_lo != 2'b00));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE_IDX = 2'(gi);
            logic w_hit;
            assign w_hit = ((i_hsize == HSIZE_BYTE) && (i_addr_lo == LANE_IDX))
                        || ((i_hsize == HSIZE_HALF) && (i_addr_lo[1] == LANE_IDX[1]))
                        ||  (i_hsize == HSIZE_WORD);
            assign o_lanes[gi] = w_hit && !o_illegal;
        end
    endgenerate

endmodule

// File: rtl/ahb_sram_bridge.sv
// Zero-wait AHB-Lite slave onto a single-port synchronous SRAM. Writes that
// collide with a read on the SRAM port park in a one-entry buffer.
module ahb_sram_bridge
    import ahb_sram_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic                CLK,
    input  logic                RST,
    ahb_sram_bridge_if.slave    bus
);

    logic [LANES-1:0]  w_lanes;
    logic              w_illegal;
    logic              w_accept;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_err_acc;
    logic [AW-1:0]     w_haddr_word;
    logic              w_buf_load;
    logic              w_buf_hit;
    logic [DATA_W-1:0] w_merge_mask;
    logic              w_sram_cs;
    logic [LANES-1:0]  w_sram_wren;
    logic [AW-1:0]     w_sram_addr;
    logic [DATA_W-1:0] w_sram_wdata;
    logic              w_unused;

    state_t            r_state;
    logic              r_hreadyout;
    logic              r_hresp;
    logic              r_rd_dphase;
    logic [AW-1:0]     r_rd_addr;
    logic              r_wr_dphase;
    logic [AW-1:0]     r_wr_addr;
    logic [LANES-1:0]  r_wr_lanes;
    logic              r_buf_valid;
    logic [AW-1:0]     r_buf_addr;
    logic [LANES-1:0]  r_buf_lanes;
    logic [DATA_W-1:0] r_buf_data;

    ahb_sram_lane_decode u_lane_decode (
        .i_hsize   (bus.HSIZE),
        .i_addr_lo (bus.HADDR[1:0]),
        .o_lanes   (w_lanes),
        .o_illegal (w_illegal)
    );

    // Reset also masks acceptance so nothing reaches the SRAM while RST is high.
    assign w_accept     = !RST && bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign w_rd_acc     = w_accept && !bus.HWRITE && !w_illegal;
    assign w_wr_acc     = w_accept &&  bus.HWRITE && !w_illegal;
    assign w_err_acc    = w_accept &&  w_illegal;
    assign w_haddr_word = bus.HADDR[AW+1:2];
    assign w_unused     = ^{bus.HADDR[31:AW+2], bus.HTRANS[0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ERR2: begin
                    if (w_err_acc) begin
                        r_state     <= ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b1;
                    end else begin
                        r_state     <= IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
                ERR1: begin
                    r_state     <= ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                end
            endcase
        end
    end

    // A data-phase write is parked when a read owns the port or the buffer is
    // itself committing this cycle; either way the write is never lost.
    assign w_buf_load = r_wr_dphase && (w_rd_acc || r_buf_valid);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_dphase <= 1'b0;
            r_wr_dphase <= 1'b0;
            r_buf_valid <= 1'b0;
        end else begin
            r_rd_dphase <= w_rd_acc;
            r_wr_dphase <= w_wr_acc;
            if (w_buf_load) begin
                r_buf_valid <= 1'b1;
            end else if (r_buf_valid && !w_rd_acc) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_rd_acc) begin
            r_rd_addr <= w_haddr_word;
        end
        if (w_wr_acc) begin
            r_wr_addr  <= w_haddr_word;
            r_wr_lanes <= w_lanes;
        end
        if (w_buf_load) begin
            r_buf_addr  <= r_wr_addr;
            r_buf_lanes <= r_wr_lanes;
            r_buf_data  <= bus.HWDATA;
        end
    end

    // Port arbitration: accepted read, then buffered write, then live write.
    always_comb begin
        w_sram_cs    = 1'b0;
        w_sram_wren  = '0;
        w_sram_addr  = w_haddr_word;
        w_sram_wdata = bus.HWDATA;
        if (!RST) begin
            if (w_rd_acc) begin
                w_sram_cs = 1'b1;
            end else if (r_buf_valid) begin
                w_sram_cs    = 1'b1;
                w_sram_wren  = r_buf_lanes;
                w_sram_addr  = r_buf_addr;
                w_sram_wdata = r_buf_data;
            end else if (r_wr_dphase) begin
                w_sram_cs    = 1'b1;
                w_sram_wren  = r_wr_lanes;
                w_sram_addr  = r_wr_addr;
            end
        end
    end

    assign bus.SRAMCS    = w_sram_cs;
    assign bus.SRAMWREN  = w_sram_wren;
    assign bus.SRAMADDR  = w_sram_addr;
    assign bus.SRAMWDATA = w_sram_wdata;

    assign w_buf_hit    = r_buf_valid && (r_buf_addr == r_rd_addr);
    assign w_merge_mask = w_buf_hit ? lane_mask(r_buf_lanes) : '0;

    assign bus.HRDATA    = (r_rd_dphase && !RST)
                         ? ((bus.SRAMRDATA & ~w_merge_mask) | (r_buf_data & w_merge_mask))
                         : '0;
    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;

endmodule

// File: doc/ahb_sram_bridge.md
AHB_SRAM_BRIDGE -- requirements
Module: ahb_sram_bridge

Interface
REQ-001 Parameter AW, default 16: SRAM word-address width; byte address space is 2^(AW+2).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 HSEL  input  1  slave select.
REQ-005 HREADY  input  1  bus ready (previous transfer complete).
REQ-006 HTRANS  input  2  transfer type; NONSEQ and SEQ are active.
REQ-007 HSIZE  input  3  transfer size.
REQ-008 HWRITE  input  1  1 = write.
REQ-009 HADDR  input  32  byte address; bits [AW+1:2] are used.
REQ-010 HWDATA  input  32  write data, valid in the data phase.
REQ-011 HREADYOUT  output  1  slave ready.
REQ-012 HRESP  output  1  1 = ERROR.
REQ-013 HRDATA  output  32  read data.
REQ-014 SRAMADDR  output  AW  SRAM word address.
REQ-015 SRAMWDATA  output  32  SRAM write data.
REQ-016 SRAMWREN  output  4  SRAM byte write enables.
REQ-017 SRAMCS  output  1  SRAM chip select.
REQ-018 SRAMRDATA  input  32  SRAM read data, valid one cycle after a read access.

Function
REQ-019 A transfer SHALL be accepted only when HSEL & HREADY & HTRANS[1] are all 1; IDLE and BUSY transfers cause no SRAM access.
REQ-020 Byte lanes SHALL be decoded as follows: HSIZE=0 gives lane HADDR[1:0]; HSIZE=1 gives lanes 1:0 or 3:2 by HADDR[1]; HSIZE=2 gives all four lanes.
REQ-021 An accepted transfer with HSIZE>2, or misaligned for its size, SHALL be an error: no SRAM access, and the FSM runs IDLE -> ERR1 -> ERR2 -> IDLE.
REQ-022 In ERR1 the block SHALL drive HREADYOUT=0 and HRESP=1; in ERR2, HREADYOUT=1 and HRESP=1; in IDLE, HREADYOUT=1 and HRESP=0 (zero-wait otherwise).
REQ-023 An accepted read SHALL drive SRAMCS=1, SRAMWREN=0 and SRAMADDR=HADDR[AW+1:2] combinationally in its address-phase cycle.
REQ-024 In the read's data phase, HRDATA SHALL equal SRAMRDATA, except that lanes covered by a valid write buffer entry with a matching address are replaced by buffer data.
REQ-025 HRDATA SHALL be 0 in any cycle that is not a read data phase.
REQ-026 An accepted write SHALL register its word address and lanes; in the data phase HWDATA is written to SRAM that same cycle when no read is accepted in that cycle.
REQ-027 If a read is accepted in a write's data phase, the write (address, lanes, HWDATA) SHALL go into a one-entry buffer instead.
REQ-028 A valid buffer entry SHALL be written to SRAM in the first cycle with no accepted read, then invalidated.
REQ-029 Priority of the SRAM port per cycle SHALL be: accepted read > buffered write > current data-phase write.
REQ-030 A data-phase write that loses to a buffered write SHALL replace the buffer entry in the same cycle the old entry commits; no write is ever dropped.
REQ-031 SRAMWDATA SHALL carry the data of the write being committed; SRAMWREN SHALL carry its lanes with SRAMCS=1.

Reset
REQ-032 While RST=1 the block SHALL clear the buffer valid flag and all data-phase flags and return the FSM to IDLE.
REQ-033 While RST=1 the outputs SHALL be HREADYOUT=1, HRESP=0, HRDATA=0, SRAMCS=0 and SRAMWREN=0.
REQ-034 A write pending at reset SHALL be discarded.

Structure
REQ-035 Package ahb_sram_pkg SHALL hold the HTRANS/HSIZE encodings, the FSM state enum (IDLE, ERR1, ERR2) and the lane-width constants.
REQ-036 Lane and alignment decode SHALL be one sub-module, ahb_sram_lane_decode, that outputs lanes[3:0] and an illegal flag.

Verification
REQ-037 Word write at HADDR=0x10 with HWDATA=0xDEADBEEF, then a read -> SRAMADDR=4 and SRAMWREN=0xF; HRDATA=0xDEADBEEF.
REQ-038 Byte write at HADDR=0x13 with HWDATA=0xAB000000 -> SRAMWREN=4'b1000 and SRAMWDATA[31:24]=0xAB.
REQ-039 Back-to-back write 0x20=0x11223344 then read 0x20 -> the write is buffered; HRDATA=0x11223344 via merge; SRAMWREN=0xF in the next idle cycle.
REQ-040 Halfword at HADDR=0x01 -> HREADYOUT/HRESP sequence 0/1, then 1/1, then 1/0; SRAMCS stays 0.
REQ-041 RST=1 while a buffered write is pending -> SRAMWREN stays 0 and a later read of that address returns the old SRAM data.
REQ-042 IDLE and BUSY HTRANS with HSEL=1 -> SRAMCS=0, HREADYOUT=1 and HRESP=0.
